ysyx_23060111_mem_arb: RTL and testbench
========================================

YSYX_23060111_MEM_ARB -- requirements
Module: ysyx_23060111_mem_arb

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, max cycles waited for a memory response (minimum 2).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset: asynchronous assertion, active-low (0 = reset).
REQ-005 SHALL have port ifu_req_valid  in  1  IFU fetch request.
REQ-006 SHALL have port ifu_req_ready  out  1  IFU request accepted this cycle.
REQ-007 SHALL have port ifu_addr  in  AW  fetch address.
REQ-008 SHALL have port ifu_resp_valid  out  1  one-cycle fetch response strobe.
REQ-009 SHALL have port lsu_req_valid  in  1  LSU load/store request.
REQ-010 SHALL have port lsu_req_ready  out  1  LSU request accepted this cycle.
REQ-011 SHALL have port lsu_addr  in  AW  load/store address.
REQ-012 SHALL have port lsu_wen  in  1  1 = store, 0 = load.
REQ-013 SHALL have port lsu_wdata  in  32  store data.
REQ-014 SHALL have port lsu_wmask  in  4  store byte mask.
REQ-015 SHALL have port lsu_resp_valid  out  1  one-cycle load/store response strobe.
REQ-016 SHALL have port resp_rdata  out  32  response data, meaningful only while ifu_resp_valid or lsu_resp_valid is 1.
REQ-017 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_addr out AW, mem_wen out 1, mem_wdata out 32, mem_wmask out 4: the single shared memory request channel.
REQ-018 SHALL have ports mem_resp_valid in 1, mem_rdata in 32: the shared memory response channel.
REQ-019 SHALL have port timeout_flag  out  1  sticky flag, set when a memory response times out.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; only one transaction is outstanding at any time.
REQ-021 In IDLE with exactly one requester valid, the block SHALL assert that requester's ready combinationally in the same cycle.
REQ-022 In IDLE with both requesters valid, the block SHALL grant the requester that was not granted last (round-robin); last_grant resets to IFU, so the first tie goes to LSU.
REQ-023 Both ready outputs SHALL be 0 outside IDLE, and at most one ready SHALL be 1 in any cycle.
REQ-024 On an accept edge (valid & ready), the block SHALL latch the owner, address, wen, wdata and wmask, update last_grant, and move to ISSUE. IFU requests latch wen=0, wmask=0 and wdata=0.
REQ-025 In ISSUE, the block SHALL hold mem_req_valid=1 with the latched payload stable until mem_req_ready=1, then move to WAIT and clear the timeout counter.
REQ-026 mem_req_valid SHALL be 0 in every state except ISSUE; in other states mem_addr, mem_wen, mem_wdata and mem_wmask SHALL be 0.
REQ-027 In WAIT, mem_resp_valid=1 SHALL latch mem_rdata into resp_rdata and move to RESP; stores also wait for mem_resp_valid as their acknowledge.
REQ-028 In WAIT, the counter SHALL increment each cycle without a response. At count TIMEOUT-1 with no response, the block SHALL move to RESP with resp_rdata=0 and set timeout_flag.
REQ-029 In RESP, the owner's resp_valid SHALL be 1 for exactly one cycle, the non-owner's resp_valid SHALL stay 0, and the next state SHALL be IDLE.
REQ-030 mem_resp_valid outside WAIT SHALL be ignored with no state change.
REQ-031 Minimum latency: accept at cycle T, mem_req_valid at T+1; if mem_req_ready=1 at T+1 and mem_resp_valid=1 at T+2, resp_valid=1 at T+3. Earliest next accept is at T+4.
REQ-032 timeout_flag SHALL remain 1 until reset.

Reset
REQ-033 While rst=0, the block SHALL be in state IDLE with last_grant=IFU, counter=0, and every output 0, including both ready outputs, resp_rdata and timeout_flag.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately; no response strobe SHALL be produced for it.
REQ-035 After rst rises, the block SHALL accept a request in the first cycle without a warm-up delay.

Verification
REQ-036 Single IFU fetch: ifu_addr=0x80000000, memory ready immediately, rdata=0x00100073 one cycle later -> mem_addr=0x80000000 at T+1, ifu_resp_valid=1 with resp_rdata=0x00100073 at T+3, lsu_resp_valid stays 0.
REQ-037 Simultaneous requests after reset, both held valid, three rounds -> grant order LSU, IFU, LSU, and ready is never 1 on both requesters in the same cycle.
REQ-038 LSU store: addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, mem_req_ready held 0 for 3 cycles -> payload stable throughout ISSUE, then one lsu_resp_valid after the ack.
REQ-039 Memory never responds with TIMEOUT=16 -> after 16 WAIT cycles, the owner's resp_valid=1 with resp_rdata=0 and timeout_flag=1, and the flag is still 1 after the next successful transaction.
REQ-040 rst pulsed low during WAIT, then a late mem_resp_valid arrives -> no resp_valid pulse, all outputs 0, and a new IFU request is accepted in the first cycle after release.

Source files
------------

// File: rtl/ysyx_23060111_mem_arb.sv
// ysyx_23060111_mem_arb
//   Two-requester (IFU fetch, LSU load/store) arbiter onto a single shared
//   memory request/response channel. One transaction is in flight at a time;
//   ties are broken round-robin. A memory that never answers is cut off after
//   TIMEOUT cycles in WAIT, the requester gets a zero response and a sticky
//   timeout_flag is raised.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   ifu_req_*/ifu_addr  fetch request channel, ifu_resp_valid strobe
//   lsu_req_*/lsu_*     load/store request channel, lsu_resp_valid strobe
//   resp_rdata          shared response data for whichever strobe is high
//   mem_req_*/mem_*     shared memory request channel
//   mem_resp_valid/mem_rdata  shared memory response channel
//   timeout_flag        sticky, set on a memory response timeout
module ysyx_23060111_mem_arb #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_resp_valid,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [31:0]   lsu_wdata,
    input  logic [3:0]    lsu_wmask,
    output logic          lsu_resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wmask,
    input  logic          mem_resp_valid,
    input  logic [31:0]   mem_rdata,
    output logic          timeout_flag
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    // Counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e          state_q;
    logic            owner_lsu_q;   // 1 = current transaction belongs to LSU
    logic            last_lsu_q;    // 1 = last grant went to LSU
    logic [AW-1:0]   addr_q;
    logic            wen_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wmask_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     rdata_q;
    logic            tflag_q;

    logic idle;
    assign idle = (state_q == IDLE);

    // Ready is combinational in IDLE. On a tie the side that was not granted
    // last wins. Gated by rst so nothing is accepted or shown while in reset.
    assign ifu_req_ready = rst && idle && ifu_req_valid && (!lsu_req_valid || last_lsu_q);
    assign lsu_req_ready = rst && idle && lsu_req_valid && (!ifu_req_valid || !last_lsu_q);

    logic issue;
    assign issue         = (state_q == ISSUE);
    assign mem_req_valid = issue;
    assign mem_addr      = issue ? addr_q  : '0;
    assign mem_wen       = issue & wen_q;
    assign mem_wdata     = issue ? wdata_q : '0;
    assign mem_wmask     = issue ? wmask_q : '0;

    assign ifu_resp_valid = (state_q == RESP) && !owner_lsu_q;
    assign lsu_resp_valid = (state_q == RESP) &&  owner_lsu_q;
    assign resp_rdata     = rdata_q;
    assign timeout_flag   = tflag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_lsu_q <= 1'b0;
            last_lsu_q  <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            tflag_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ifu_req_ready || lsu_req_ready) begin
                        // IFU fetches carry no write payload.
                        owner_lsu_q <= lsu_req_ready;
                        last_lsu_q  <= lsu_req_ready;
                        addr_q      <= lsu_req_ready ? lsu_addr  : ifu_addr;
                        wen_q       <= lsu_req_ready & lsu_wen;
                        wdata_q     <= lsu_req_ready ? lsu_wdata : 32'h0;
                        wmask_q     <= lsu_req_ready ? lsu_wmask : 4'h0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A real response wins over a timeout in the same cycle.
                    if (mem_resp_valid) begin
                        rdata_q <= mem_rdata;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rdata_q <= 32'h0;
                        tflag_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060111_mem_arb.sv
module tb_ysyx_23060111_mem_arb;

    logic        clk, rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        timeout_flag;

    int n_chk = 0;
    int n_err = 0;

    ysyx_23060111_mem_arb #(.AW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
        .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .timeout_flag(timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From the accept cycle: memory takes the request at once and answers the
    // next cycle. Returns positioned in the RESP cycle.
    task automatic run_mem(input logic [31:0] rd);
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = rd;
        tick();
        mem_resp_valid = 1'b0;
    endtask

    // Both readies must never be high together.
    always @(negedge clk)
        chk("both_rdy", {63'd0, ifu_req_ready & lsu_req_ready}, 64'd0);

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        #2 rst = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        tick(); tick();

        // Reset state, with both requesters pushing.
        chk("rst_ifu_rdy", {63'd0, ifu_req_ready}, 0);
        chk("rst_lsu_rdy", {63'd0, lsu_req_ready}, 0);
        chk("rst_memv",    {63'd0, mem_req_valid}, 0);
        chk("rst_maddr",   {32'd0, mem_addr}, 0);
        chk("rst_resp",    {62'd0, ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rst_rdata",   {32'd0, resp_rdata}, 0);
        chk("rst_tflag",   {63'd0, timeout_flag}, 0);

        // Single IFU fetch, accepted in the first cycle after release.
        lsu_req_valid = 1'b0;
        ifu_addr = 32'h8000_0000;
        rst = 1'b1;
        #1;
        chk("A_ifu_rdy", {63'd0, ifu_req_ready}, 1);
        tick();                                   // T+1
        ifu_req_valid = 1'b0;
        chk("A_memv",  {63'd0, mem_req_valid}, 1);
        chk("A_maddr", {32'd0, mem_addr}, 64'h8000_0000);
        chk("A_mwen",  {59'd0, mem_wen, mem_wmask}, 0);
        chk("A_rdy_busy", {62'd0, ifu_req_ready, lsu_req_ready}, 0);
        mem_req_ready = 1'b1;
        tick();                                   // T+2
        mem_req_ready = 1'b0;
        chk("A_wait_memv", {63'd0, mem_req_valid}, 0);
        chk("A_wait_addr", {32'd0, mem_addr}, 0);
        mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0073;
        tick();                                   // T+3
        mem_resp_valid = 1'b0;
        chk("A_resp",  {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'b10);
        chk("A_rdata", {32'd0, resp_rdata}, 64'h0010_0073);
        tick();                                   // T+4
        chk("A_resp_gone", {62'd0, ifu_resp_valid, lsu_resp_valid}, 0);

        // Round-robin with both held valid: LSU, IFU, LSU.
        for (int r = 0; r < 3; r++) begin
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
            lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
            #1;
            chk($sformatf("B%0d_grant", r), {62'd0, ifu_req_ready, lsu_req_ready},
                (r == 1) ? 64'b10 : 64'b01);
            run_mem(32'h1111_0000 + r);
            chk($sformatf("B%0d_resp", r), {62'd0, ifu_resp_valid, lsu_resp_valid},
                (r == 1) ? 64'b10 : 64'b01);
            chk($sformatf("B%0d_rdata", r), {32'd0, resp_rdata}, 64'h1111_0000 + r);
            tick();
        end

        // LSU store with memory stalling three cycles.
        lsu_req_valid = 1'b1; lsu_wen = 1'b1;
        lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        #1;
        chk("C_lsu_rdy", {63'd0, lsu_req_ready}, 1);
        tick();
        lsu_req_valid = 1'b0; lsu_wdata = 32'h0; lsu_addr = 32'h0; lsu_wmask = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_req_ready = 1'b1;
            #1;
            chk($sformatf("C%0d_payload", i),
                {mem_req_valid, mem_wen, mem_wmask, 26'd0, mem_addr[31:0]},
                {1'b1, 1'b1, 4'hF, 26'd0, 32'h8000_1000});
            chk($sformatf("C%0d_wdata", i), {32'd0, mem_wdata}, 64'hDEAD_BEEF);
            tick();
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("C_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'b01);
        tick();
        chk("C_resp_once", {62'd0, ifu_resp_valid, lsu_resp_valid}, 0);

        // Memory never answers: timeout after 16 WAIT cycles.
        chk("D_flag_pre", {63'd0, timeout_flag}, 0);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        mem_rdata = 32'h1234_5678;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();                                   // first WAIT cycle
        mem_req_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (ifu_resp_valid !== 1'b0 || timeout_flag !== 1'b0)
                chk($sformatf("D_early%0d", i), {62'd0, ifu_resp_valid, timeout_flag}, 0);
            tick();
        end
        chk("D_resp",  {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'b10);
        chk("D_rdata", {32'd0, resp_rdata}, 0);
        chk("D_flag",  {63'd0, timeout_flag}, 1);
        tick();
        ifu_req_valid = 1'b1;
        #1;
        run_mem(32'hCAFE_F00D);
        chk("D2_rdata", {32'd0, resp_rdata}, 64'hCAFE_F00D);
        chk("D2_flag",  {63'd0, timeout_flag}, 1);
        tick();

        // Reset during WAIT, late response, immediate re-accept.
        ifu_req_valid = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();                                   // still WAIT
        rst = 1'b0;
        #1;
        chk("E_rst_flag", {63'd0, timeout_flag}, 0);
        chk("E_rst_memv", {63'd0, mem_req_valid}, 0);
        mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        chk("E_rst_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 0);
        tick();
        chk("E_rst_rdata", {32'd0, resp_rdata}, 0);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        rst = 1'b1;
        #1;
        chk("E_rel_rdy", {63'd0, ifu_req_ready}, 1);
        tick();
        ifu_req_valid = 1'b0;
        chk("E_late_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 0);
        chk("E_issue", {31'd0, mem_req_valid, mem_addr}, {31'd0, 1'b1, 32'h8000_0100});
        tick();                                   // resp outside WAIT ignored
        chk("E_hold", {63'd0, mem_req_valid}, 1);
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_00AA;
        tick();
        mem_resp_valid = 1'b0;
        chk("E_resp", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'b10);
        chk("E_rdata", {32'd0, resp_rdata}, 64'hAA);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
